calculate_weight_pipe: RTL and testbench

//  Parametrised defuzzification weight engine: per fired rule, clips a triangular output MF {a,b,c} at
//  the rule's consequent degree h, computing trapezoid area and area-weighted centre of gravity.

---
 rtl/calculate_weight_pipe.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_calculate_weight_pipe.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculate_weight_pipe.sv
// rtl/calculate_weight_pipe.sv - clipped-triangle area / weighted-centre engine with input FIFO and optional burst accumulation
module calculate_weight_pipe #(
    parameter int W     = 32,
    parameter int FRAC  = 12,
    parameter int DEPTH = 16,
    parameter int ACCUM = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_degree,
    input  logic [3*W-1:0]           in_mf,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_area,
    output logic [W-1:0]             out_wsum,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [1:0]               err_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    // Pipeline storage width: holds differences and clip points of W-bit operands.
    localparam int DW = W + 3;
    // Working width for products: no intermediate can overflow before saturation.
    localparam int XW = 2 * W + 4;
    localparam int FW = 4 * W + 1;

    localparam logic signed [W-1:0]  ONE  = {{(W-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [XW-1:0] SMAX = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [XW-1:0] SMIN = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic signed [W-1:0]  MAXW = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  MINW = {1'b1, {(W-1){1'b0}}};

    function automatic logic signed [XW-1:0] sx_w(input logic signed [W-1:0] v);
        return {{(XW-W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [XW-1:0] sx_d(input logic signed [DW-1:0] v);
        return {{(XW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SMAX) begin
            return MAXW;
        end else if (v < SMIN) begin
            return MINW;
        end
        return W'(v);
    endfunction

    function automatic logic ovf(input logic signed [XW-1:0] v);
        return (v > SMAX) || (v < SMIN);
    endfunction

    // ------------------------------------------------------------------
    // Input FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [FW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push;
    logic           pop;
    logic           en;

    assign en       = ~out_valid | out_ready;
    assign in_ready = (fifo_level < LW'(DEPTH));
    assign push     = in_valid & in_ready;
    assign pop      = en & (fifo_level != '0);

    // FIFO storage write; contents need no reset since level gates reads
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_degree, in_mf};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    logic signed [W-1:0] f_a, f_b, f_c, f_h;
    logic                f_last;
    assign {f_last, f_h, f_a, f_b, f_c} = mem[rd_ptr];

    // ------------------------------------------------------------------
    // S1: clamp degree, order check, clip-height products
    // ------------------------------------------------------------------
    logic signed [W-1:0]  h_clamp;
    logic                 ord_ok;
    logic signed [XW-1:0] p1_full, p2_full;

    // Degree clamp to [0, ONE] and the two edge offsets of the clipped top
    always_comb begin
        h_clamp = f_h;
        if (f_h[W-1]) begin
            h_clamp = '0;
        end else if (f_h > ONE) begin
            h_clamp = ONE;
        end
        ord_ok  = (f_a <= f_b) && (f_b <= f_c);
        p1_full = (sx_w(h_clamp) * (sx_w(f_b) - sx_w(f_a))) >>> FRAC;
        p2_full = (sx_w(h_clamp) * (sx_w(f_c) - sx_w(f_b))) >>> FRAC;
    end

    logic                 s1_v, s1_last, s1_bad;
    logic signed [W-1:0]  s1_a, s1_c, s1_h;
    logic signed [DW-1:0] s1_p1, s1_p2;

    // S1 valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v <= 1'b0;
        end else if (en) begin
            s1_v <= pop;
        end
    end

    // S1 data capture on pop
    always_ff @(posedge clk) begin
        if (pop) begin
            s1_a    <= f_a;
            s1_c    <= f_c;
            s1_h    <= h_clamp;
            s1_p1   <= DW'(p1_full);
            s1_p2   <= DW'(p2_full);
            s1_bad  <= ~ord_ok;
            s1_last <= f_last;
        end
    end

    // ------------------------------------------------------------------
    // S2: clipped top corners x1, x2
    // ------------------------------------------------------------------
    logic signed [XW-1:0] x1_full, x2_full;
    assign x1_full = sx_w(s1_a) + sx_d(s1_p1);
    assign x2_full = sx_w(s1_c) - sx_d(s1_p2);

    logic                 s2_v, s2_last, s2_bad;
    logic signed [W-1:0]  s2_a, s2_c, s2_h;
    logic signed [DW-1:0] s2_x1, s2_x2;

    // S2 register stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_v <= 1'b0;
        end else if (en) begin
            s2_v <= s1_v;
        end
    end

    // S2 data advance
    always_ff @(posedge clk) begin
        if (en) begin
            s2_a    <= s1_a;
            s2_c    <= s1_c;
            s2_h    <= s1_h;
            s2_x1   <= DW'(x1_full);
            s2_x2   <= DW'(x2_full);
            s2_bad  <= s1_bad;
            s2_last <= s1_last;
        end
    end

    // ------------------------------------------------------------------
    // S3: trapezoid double-area product and centre of gravity
    // ------------------------------------------------------------------
    logic signed [XW-1:0] span_full, m_full, cg_full;
    logic signed [W+1:0]  cg_sum;

    // Base plus top times height; centre is the mean of the four corners
    always_comb begin
        span_full = sx_w(s2_c) - sx_w(s2_a);
        m_full    = (span_full + (sx_d(s2_x2) - sx_d(s2_x1))) * sx_w(s2_h);
        cg_full   = sx_w(s2_a) + sx_d(s2_x1) + sx_d(s2_x2) + sx_w(s2_c);
        cg_sum    = (W+2)'(cg_full);
    end

    logic                 s3_v, s3_last, s3_bad, s3_one;
    logic signed [DW-1:0] s3_span;
    logic signed [XW-1:0] s3_m;
    logic signed [W-1:0]  s3_cg;

    // S3 register stage
    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_v <= 1'b0;
        end else if (en) begin
            s3_v <= s2_v;
        end
    end

    // S3 data advance
    always_ff @(posedge clk) begin
        if (en) begin
            s3_span <= DW'(span_full);
            s3_m    <= m_full;
            s3_cg   <= W'(cg_sum >>> 2);
            s3_one  <= (s2_h == ONE);
            s3_bad  <= s2_bad;
            s3_last <= s2_last;
        end
    end

    // ------------------------------------------------------------------
    // S4: area, weighted sum, saturation, optional burst accumulation
    // ------------------------------------------------------------------
    logic signed [XW-1:0] area_x, wsum_x, acc_area_x, acc_wsum_x;
    logic signed [W-1:0]  area_s, wsum_s, r_area, r_wsum;
    logic signed [W-1:0]  acc_area, acc_wsum, acc_area_n, acc_wsum_n;
    logic                 r_sat, acc_sat;

    // Full-height beats use the exact triangle area to avoid rounding loss
    always_comb begin
        area_x = s3_one ? (sx_d(s3_span) >>> 1) : (s3_m >>> (FRAC + 1));
        area_s = sat(area_x);
        wsum_x = (sx_w(s3_cg) * sx_w(area_s)) >>> FRAC;
        wsum_s = sat(wsum_x);
        if (s3_bad) begin
            r_area = '0;
            r_wsum = '0;
            r_sat  = 1'b0;
        end else begin
            r_area = area_s;
            r_wsum = wsum_s;
            r_sat  = ovf(area_x) | ovf(wsum_x);
        end
        acc_area_x = sx_w(acc_area) + sx_w(r_area);
        acc_wsum_x = sx_w(acc_wsum) + sx_w(r_wsum);
        acc_area_n = sat(acc_area_x);
        acc_wsum_n = sat(acc_wsum_x);
        acc_sat    = ovf(acc_area_x) | ovf(acc_wsum_x);
    end

    // Output register and burst accumulators; frozen while output is stalled
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_area  <= '0;
            out_wsum  <= '0;
            out_last  <= 1'b0;
            acc_area  <= '0;
            acc_wsum  <= '0;
        end else if (en) begin
            if (ACCUM != 0) begin
                out_valid <= s3_v & s3_last;
                if (s3_v) begin
                    if (s3_last) begin
                        out_area <= acc_area_n;
                        out_wsum <= acc_wsum_n;
                        out_last <= 1'b1;
                        acc_area <= '0;
                        acc_wsum <= '0;
                    end else begin
                        acc_area <= acc_area_n;
                        acc_wsum <= acc_wsum_n;
                    end
                end
            end else begin
                out_valid <= s3_v;
                if (s3_v) begin
                    out_area <= r_area;
                    out_wsum <= r_wsum;
                    out_last <= s3_last;
                end
            end
        end
    end

    // Sticky error flags: [0] saturation, [1] MF point order violated
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_sticky <= 2'b00;
        end else begin
            if (pop && !ord_ok) begin
                err_sticky[1] <= 1'b1;
            end
            if (en && s3_v && (r_sat || ((ACCUM != 0) && acc_sat))) begin
                err_sticky[0] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calculate_weight_pipe.sv
// tb/tb_calculate_weight_pipe.sv - directed scoreboard bench for calculate_weight_pipe
module tb_calculate_weight_pipe;

    typedef struct {
        logic [31:0] a, b, c, h, ea, ew;
    } vec_t;

    typedef struct {
        logic [31:0] area;
        logic [31:0] wsum;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_in_degree, a_out_area, a_out_wsum;
    logic [95:0] a_in_mf;
    logic [2:0]  a_fifo_level;
    logic [1:0]  a_err;

    logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_last;
    logic [31:0] b_in_degree, b_out_area, b_out_wsum;
    logic [95:0] b_in_mf;
    logic [4:0]  b_fifo_level;
    logic [1:0]  b_err;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t qa[$];
    exp_t qb[$];
    vec_t vt[8];

    calculate_weight_pipe #(.W(32), .FRAC(12), .DEPTH(4), .ACCUM(0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_degree(a_in_degree),
        .in_mf(a_in_mf), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_area(a_out_area),
        .out_wsum(a_out_wsum), .out_last(a_out_last),
        .fifo_level(a_fifo_level), .err_sticky(a_err)
    );

    calculate_weight_pipe #(.W(32), .FRAC(12), .DEPTH(16), .ACCUM(1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_degree(b_in_degree),
        .in_mf(b_in_mf), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_area(b_out_area),
        .out_wsum(b_out_wsum), .out_last(b_out_last),
        .fifo_level(b_fifo_level), .err_sticky(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Output scoreboards: compare each transferred result with the oldest expectation
    always @(negedge clk) begin
        if (rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_out", 64'(a_out_area), 64'hDEAD);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_area", 64'(a_out_area), 64'(e.area));
                check("a_wsum", 64'(a_out_wsum), 64'(e.wsum));
                check("a_last", 64'(a_out_last), 64'(e.last));
            end
        end
    end

    always @(negedge clk) begin
        if (rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_out", 64'(b_out_area), 64'hDEAD);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_area", 64'(b_out_area), 64'(e.area));
                check("b_wsum", 64'(b_out_wsum), 64'(e.wsum));
                check("b_last", 64'(b_out_last), 64'(e.last));
            end
        end
    end

    // Drive one beat into dut_a; called just after a rising edge, returns just after the accepting edge
    task automatic send_a(input vec_t v, input logic last);
        int t = 0;
        a_in_mf = {v.a, v.b, v.c};
        a_in_degree = v.h;
        a_in_last = last;
        a_in_valid = 1'b1;
        @(negedge clk);
        while (!a_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("a_accept_bound", 64'(t < 50), 64'd1);
        @(posedge clk);
        qa.push_back('{v.ea, v.ew, last});
        #1 a_in_valid = 1'b0;
    endtask

    task automatic send_b(input vec_t v, input logic last, input logic [31:0] ea, input logic [31:0] ew);
        int t = 0;
        b_in_mf = {v.a, v.b, v.c};
        b_in_degree = v.h;
        b_in_last = last;
        b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("b_accept_bound", 64'(t < 50), 64'd1);
        @(posedge clk);
        if (last) qb.push_back('{ea, ew, 1'b1});
        #1 b_in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 64'(qa.size() + qb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx;
        logic acc;

        vt[0] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_0800, 32'h0000_0C00, 32'h0000_0C00};
        vt[1] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000};
        vt[2] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_1800, 32'h0000_1000, 32'h0000_1000};
        vt[3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000};
        vt[4] = '{32'h0000_1000, 32'h0000_3000, 32'h0000_4000, 32'h0000_0800, 32'h0000_1200, 32'h0000_2F40};
        vt[5] = '{32'hFFFF_D000, 32'hFFFF_E000, 32'hFFFF_F000, 32'h0000_0800, 32'h0000_0C00, 32'hFFFF_E800};
        vt[6] = '{32'h0000_2000, 32'h0000_1000, 32'h0000_0000, 32'h0000_0800, 32'h0000_0000, 32'h0000_0000};
        vt[7] = '{32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h0000_1000, 32'h1000_0000, 32'h7FFF_FFFF};

        rst = 1'b0;
        a_in_valid = 1'b0; a_in_last = 1'b0; a_in_degree = '0; a_in_mf = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_in_degree = '0; b_in_mf = '0; b_out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_a_out_area", 64'(a_out_area), 64'd0);
        check("rst_a_out_wsum", 64'(a_out_wsum), 64'd0);
        check("rst_a_out_last", 64'(a_out_last), 64'd0);
        check("rst_a_fifo_level", 64'(a_fifo_level), 64'd0);
        check("rst_a_err", 64'(a_err), 64'd0);
        check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("rst_b_out_area", 64'(b_out_area), 64'd0);
        check("rst_b_out_wsum", 64'(b_out_wsum), 64'd0);
        check("rst_b_out_last", 64'(b_out_last), 64'd0);
        check("rst_b_fifo_level", 64'(b_fifo_level), 64'd0);
        check("rst_b_err", 64'(b_err), 64'd0);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Latency: one beat into an empty FIFO shows at the fourth edge after acceptance
        send_a(vt[0], 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("lat_not_early", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_on_time", 64'(a_out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back beats: full height, clamped, negative degree, asymmetric, negative axis
        for (int i = 1; i < 6; i++) send_a(vt[i], i[0]);
        drain();
        check("a_err_clean", 64'(a_err), 64'd0);

        // Backpressure: pipeline absorbs 4 beats, FIFO 4 more, then in_ready drops
        a_out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (idx < 10) begin
                a_in_mf = {vt[idx % 6].a, vt[idx % 6].b, vt[idx % 6].c};
                a_in_degree = vt[idx % 6].h;
                a_in_last = 1'b0;
                a_in_valid = 1'b1;
            end else begin
                a_in_valid = 1'b0;
            end
            @(negedge clk);
            acc = a_in_valid && a_in_ready;
            @(posedge clk);
            if (acc) begin
                qa.push_back('{vt[idx % 6].ea, vt[idx % 6].ew, 1'b0});
                idx++;
            end
            #1;
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        check("bp_accepted", 64'(idx), 64'd8);
        check("bp_fifo_level", 64'(a_fifo_level), 64'd4);
        check("bp_in_ready", 64'(a_in_ready), 64'd0);
        check("bp_out_held", 64'(a_out_area), 64'h0C00);
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_no_extra", 64'(a_out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Order violation, then saturation
        send_a(vt[6], 1'b0);
        drain();
        check("err_order", 64'(a_err), 64'd2);
        send_a(vt[7], 1'b0);
        drain();
        check("err_sat", 64'(a_err), 64'd3);

        // Burst accumulation: three half-height beats summed into one result
        send_b(vt[0], 1'b0, 32'h0, 32'h0);
        send_b(vt[0], 1'b0, 32'h0, 32'h0);
        send_b(vt[0], 1'b1, 32'h2400, 32'h2400);
        drain();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("b_single_out", 64'(b_out_valid), 64'd0);
        check("b_err_clean", 64'(b_err), 64'd0);
        @(posedge clk);
        #1;

        // Mid-operation reset with beats in flight and a partial burst
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_a(vt[0], 1'b0);
        send_b(vt[4], 1'b0, 32'h0, 32'h0);
        send_b(vt[4], 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_a_out_valid", 64'(a_out_valid), 64'd0);
        check("mrst_a_out_area", 64'(a_out_area), 64'd0);
        check("mrst_a_fifo_level", 64'(a_fifo_level), 64'd0);
        check("mrst_a_err", 64'(a_err), 64'd0);
        check("mrst_a_in_ready", 64'(a_in_ready), 64'd1);
        check("mrst_b_out_valid", 64'(b_out_valid), 64'd0);
        check("mrst_b_out_wsum", 64'(b_out_wsum), 64'd0);
        check("mrst_b_fifo_level", 64'(b_fifo_level), 64'd0);
        qa.delete();
        qb.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;

        // New burst after reset sums only its own beats
        send_b(vt[0], 1'b0, 32'h0, 32'h0);
        send_b(vt[1], 1'b1, 32'h1C00, 32'h1C00);
        send_a(vt[4], 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
